// File: rtl/arbitro_registro_5bits_pkg.sv
// Shared definitions for the register arbiter: FSM state encodings and
// default sizing. This is the arbitro_defs set used by the top and the selector.
package arbitro_registro_5bits_pkg;

   localparam int DEFAULT_NUM_REQ = 4;
   localparam int DEFAULT_DATA_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

endpackage

// File: rtl/arbitro_registro_5bits_selector_rr.sv
// Combinational round-robin search. It scans ptr, ptr+1, ... with modulo
// NUM_REQ wrap, and the first asserted request wins. NUM_REQ is a power of
// two, so the wrap is just the natural overflow of an IDX_W-bit add.
module selector_rr
   import arbitro_registro_5bits_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ
)(
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         winner_oh,
   output logic [$clog2(NUM_REQ)-1:0] winner_idx,
   output logic                       valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] w_cand;

   // Scan from the pointer and keep only the first hit.
   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      valid      = 1'b0;
      w_cand     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand = ptr + IDX_W'(i);
         if (!valid && req[w_cand]) begin
            valid              = 1'b1;
            winner_idx         = w_cand;
            winner_oh[w_cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_registro_5bits.sv
// Round-robin arbiter that guards one shared DATA_W-bit register.
// A requester holds req_i until it receives its ack. Every output comes
// straight from a flop.
//
//   state | meaning
//   IDLE  | no transfer; the selector winner is registered into gnt_o
//   GRANT | gnt_o shown; the write commits if the winner still requests, else abort
//   ACK   | one-cycle ack_o pulse; the pointer moves past the winner
module arbitro_registro_5bits
   import arbitro_registro_5bits_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int DATA_W  = DEFAULT_DATA_W
)(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ*DATA_W-1:0]   d_i,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic [NUM_REQ-1:0]          ack_o,
   output logic [DATA_W-1:0]           q_o,
   output logic [$clog2(NUM_REQ)-1:0]  owner_o,
   output logic                        busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t              r_state;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  r_ack;
   logic [DATA_W-1:0]   r_q;
   logic [IDX_W-1:0]    r_owner;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_win;
   logic                r_busy;

   state_t              w_state_nxt;
   logic [NUM_REQ-1:0]  w_gnt_nxt;
   logic [NUM_REQ-1:0]  w_ack_nxt;
   logic [DATA_W-1:0]   w_q_nxt;
   logic [IDX_W-1:0]    w_owner_nxt;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic [IDX_W-1:0]    w_win_nxt;
   logic                w_busy_nxt;

   logic [NUM_REQ-1:0]  w_sel_oh;
   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_sel_valid;
   logic [DATA_W-1:0]   w_d_win;

   selector_rr #(
      .NUM_REQ    (NUM_REQ)
   ) u_selector_rr (
      .req        (req_i),
      .ptr        (r_ptr),
      .winner_oh  (w_sel_oh),
      .winner_idx (w_sel_idx),
      .valid      (w_sel_valid)
   );

   // Pick the granted requester's data slice with a constant-index mux.
   always_comb begin
      w_d_win = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r_win == IDX_W'(k)) begin
            w_d_win = d_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and next-output decode. gnt and ack default to zero, so each
   // of them lasts exactly the one state that sets it.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = '0;
      w_ack_nxt   = '0;
      w_q_nxt     = r_q;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win;
      case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_gnt_nxt   = w_sel_oh;
               w_win_nxt   = w_sel_idx;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (req_i[r_win]) begin
               w_q_nxt     = w_d_win;
               w_owner_nxt = r_win;
               w_ack_nxt   = r_gnt;
               w_state_nxt = ACK;
            end else begin
               // Abort: the winner let go before the commit, so nothing is
               // written and the pointer keeps its value.
               w_state_nxt = IDLE;
            end
         end
         ACK: begin
            w_ptr_nxt   = r_win + IDX_W'(1);
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // State and output registers. Reset is synchronous and beats every state,
   // so a write or ack still in flight is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_q     <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_win   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ack   <= w_ack_nxt;
         r_q     <= w_q_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign gnt_o   = r_gnt;
   assign ack_o   = r_ack;
   assign q_o     = r_q;
   assign owner_o = r_owner;
   assign busy_o  = r_busy;

endmodule

// File: doc/arbitro_registro_5bits.md
ARBITRO_REGISTRO_5BITS -- requirements
Module: arbitro_registro_5bits

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 5, width of the shared register.
REQ-002 Ports SHALL be, clock and reset first:
- clk_i  input  1  single clock; all state changes on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  NUM_REQ  per-requester write request, held until ack.
- d_i  input  NUM_REQ*DATA_W  requester k data on d_i[k*DATA_W +: DATA_W].
- gnt_o  output  NUM_REQ  one-hot grant; all zero when no grant.
- ack_o  output  NUM_REQ  one-hot, one-cycle write-done pulse.
- q_o  output  DATA_W  shared register contents.
- owner_o  output  clog2(NUM_REQ)  index of the last successful writer.
- busy_o  output  1  high in GRANT and ACK.

Function
REQ-003 The FSM SHALL have three states: IDLE, GRANT and ACK.
REQ-004 In IDLE with req_i != 0, the block SHALL register the round-robin winner into gnt_o and move to GRANT; with req_i == 0 it SHALL stay in IDLE with gnt_o = 0.
REQ-005 The round-robin search SHALL start at pointer ptr and proceed ptr, ptr+1, ..., wrapping modulo NUM_REQ; the first asserted req_i bit wins.
REQ-006 In GRANT, if req_i[winner] is still high, q_o SHALL load the winner's d_i slice at that edge, owner_o SHALL load the winner index, and the FSM SHALL move to ACK.
REQ-007 In GRANT, if req_i[winner] has dropped (abort), the block SHALL:
- leave q_o, owner_o and ptr unchanged;
- assert no ack;
- clear gnt_o and return to IDLE.
REQ-008 In ACK, the block SHALL:
- drive ack_o one-hot on the winner for exactly one cycle;
- keep gnt_o = 0;
- set ptr to (winner+1) mod NUM_REQ;
- return to IDLE.
REQ-009 Latency SHALL be: request sampled in IDLE at cycle n -> gnt_o at n+1 -> q_o updated and ack_o high at n+2 -> IDLE at n+3; peak throughput is one write per 3 cycles.
REQ-010 A request still high in the IDLE cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-011 Changes on req_i or d_i of non-winners during GRANT or ACK SHALL be ignored.
REQ-012 gnt_o and ack_o SHALL never have more than one bit set, and SHALL never be high in the same cycle.
REQ-013 busy_o SHALL be high exactly in GRANT and ACK.

Reset
REQ-014 When rst_i is high at a clock edge, the block SHALL set state = IDLE, ptr = 0, q_o = 0, owner_o = 0, gnt_o = 0, ack_o = 0 and busy_o = 0.
REQ-015 rst_i SHALL override every state, including mid-GRANT and mid-ACK; an interrupted write is lost.
REQ-016 An ack pending at reset SHALL never appear.
REQ-017 With rst_i high, no output SHALL change except at a clock edge.

Structure
REQ-018 A shared include file arbitro_defs SHALL hold the state encodings (IDLE=2'd0, GRANT=2'd1, ACK=2'd2) and the default DATA_W/NUM_REQ localparams.
REQ-019 The round-robin search SHALL be a separate combinational sub-module, selector_rr, with these ports:
- inputs: req, ptr;
- outputs: one-hot winner, winner index, valid.
REQ-020 All outputs SHALL be registered, with no combinational path from req_i or d_i to any output.

Verification
REQ-021 Reset: rst_i high 2 cycles with req_i=4'b1111 -> all outputs 0 during and after reset; first gnt_o appears 1 cycle after rst_i falls.
REQ-022 Single write: req_i=4'b0100 with slice 2 = 5'h13 at cycle 0 -> the bench SHALL see:
- cycle 1: gnt_o=4'b0100;
- cycle 2: q_o=5'h13, owner_o=2, ack_o=4'b0100;
- cycle 3: busy_o=0.
REQ-023 Fairness: all four requesters held high with data 5'h01..5'h04 from reset -> acks in order 0,1,2,3,0, spaced 3 cycles apart; q_o follows 01,02,03,04,01.
REQ-024 Abort: requester 1 wins and drops req_i in GRANT -> no ack_o, q_o and owner_o unchanged; the next request from requester 1 still wins first (ptr unchanged).
REQ-025 Wrap: after an ack to requester 2 (ptr=3), req_i=4'b1001 -> requester 3 is acked first, then requester 0.
REQ-026 Reset mid-operation: rst_i high in a GRANT cycle with a winner holding data 5'h1F -> next cycle q_o=0, gnt_o=0, and no ack_o ever issued for that write.
